store_buffer: RTL and testbench
===============================

# store_buffer

Store-side counterpart of the load writeback path. It accepts store requests from the execute stage and aligns the byte, halfword, or word data into the correct lanes of a 32-bit word, with matching byte write strobes. Requests are queued in a small FIFO and drained to the data-memory write port over a valid/ready handshake. It also reports when a pending store overlaps a load address, so the pipeline can stall loads that would read stale memory.

## Interface
Parameters:
- DEPTH, 4, number of buffered stores; power of two, minimum 2
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridden

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous and active-low
- req_valid  in  1  store request present
- req_ready  out  1  buffer can accept a request; equals !full
- req_addr  in  32  byte address, i.e. the computed ALU address
- req_data  in  32  rs2 value; the low bits carry SB/SH data
- req_funct3  in  3  store width: 000 SB, 001 SH, 010 SW
- st_err  out  1  one-cycle pulse after a misaligned or illegal store is accepted
- mem_valid  out  1  head entry is valid
- mem_ready  in  1  memory accepts the head entry this cycle
- mem_addr  out  32  word address of the head entry; bits [1:0] are always 0
- mem_wdata  out  32  lane-aligned write data
- mem_wstrb  out  4  byte enables; bit i selects bits [8i+7:8i]
- ld_addr  in  32  byte address of the load currently in writeback/memory
- ld_hazard  out  1  combinational; some valid entry has the same word address as ld_addr

## Operation
- Offset: off = req_addr[1:0].
- SB: always legal.
  - wdata = {4{req_data[7:0]}} masked to lane off.
  - wstrb = 4'b0001 << off.
- SH: legal when off is 0 or 2.
  - wdata = req_data[15:0] << (8*off).
  - wstrb = 4'b0011 << off.
- SW: legal when off is 0.
  - wdata = req_data.
  - wstrb = 4'b1111.
- Unselected lanes of wdata are 0.
- An illegal store is any misaligned SH/SW, or any funct3 other than 000, 001 or 010. It is accepted (it consumes the handshake) but not enqueued. st_err pulses in the next cycle.
- Each enqueued entry stores {addr[31:2], wdata, wstrb}.
- Occupancy states:
  - EMPTY (count 0): mem_valid = 0.
  - PARTIAL: mem_valid = 1, req_ready = 1.
  - FULL (count = DEPTH): req_ready = 0.
- Count transitions:
  - push only: +1
  - pop only: −1
  - push and pop in the same cycle: unchanged, both pointers advance
- Pointers wrap modulo DEPTH.
- Stores drain strictly in order.
- Hazard check: compare ld_addr[31:2] against every valid entry. The comparison is word-granular, regardless of strobes.

## Timing
- Reset values, applied asynchronously on rst_n low:
  - count = 0, rd/wr pointers = 0, st_err = 0
  - mem_valid = 0, req_ready = 1, mem_wstrb = 0, mem_addr = 0, mem_wdata = 0
- Reset mid-operation discards all pending entries; none reach memory.
- Enqueue latency: an entry accepted in cycle N is presented at mem_valid in cycle N+1. There is no combinational bypass.
- req_ready depends only on registered count. When FULL, a request is not accepted, even if mem_ready is high that cycle; it becomes acceptable in the next cycle.
- When mem_valid && !mem_ready, mem_addr, mem_wdata and mem_wstrb hold stable.
- A pop occurs on mem_valid && mem_ready. The next entry, if any, appears in the next cycle.
- When EMPTY, mem_wstrb = 0 and mem_addr/mem_wdata = 0.
- ld_hazard excludes a request being accepted in the same cycle. It covers entries up to and including one being popped in the same cycle.
- st_err is registered and high for exactly one cycle per illegal accepted request.

## Structure
- Shared package holds:
  - F3_SB/F3_SH/F3_SW constants
  - a store-entry struct {addr_w[29:0], wdata[31:0], wstrb[3:0]}
  - a function mapping funct3 to its legal-offset mask
- Sub-module store_align: purely combinational. It maps (addr[1:0], data, funct3) to (wdata, wstrb, illegal). It is reused by the formal alignment checks.
- The FIFO array, pointers, count and hazard comparators live in store_buffer.

## Test plan
- Byte store: SB addr 0x1003, data 0xDEADBEEF, mem_ready=1 → next cycle mem_valid=1, mem_addr=0x1000, mem_wdata=0xEF000000, mem_wstrb=4'b1000.
- Halfword store and misaligned halfword:
  - SH addr 0x2002, data 0x0000ABCD → wdata 0xABCD0000, wstrb 4'b1100.
  - SH addr 0x2001 → accepted, nothing enqueued, st_err=1 for exactly one cycle.
- Fill and drain: DEPTH=4, mem_ready=0, push 4 SWs (0x10, 0x14, 0x18, 0x1C).
  - req_ready drops after the 4th push.
  - Raise mem_ready → 4 pops in order, one per cycle, then mem_valid=0.
- Simultaneous push/pop at count 2: count stays 2, ordering is preserved, and pointer wrap is exercised over 10 cycles.
- Hazard: pending SB at 0x3001, ld_addr=0x3002 → ld_hazard=1; ld_addr=0x3004 → ld_hazard=0.
- Reset mid-operation: 3 entries pending, assert rst_n=0 asynchronously → all outputs go to reset values immediately and no write reaches memory after release.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer: funct3 encodings, queued entry
// layout, occupancy states and the per-width legal-offset table.
package store_buffer_pkg;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef struct packed {
    logic [29:0] addr_w;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } st_entry_t;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_PARTIAL,
    OCC_FULL
  } occ_e;

  // Bit k set means byte offset k is a legal start for this store width.
  function automatic logic [3:0] legal_off_mask(input logic [2:0] funct3);
    logic [3:0] mask;
    case (funct3)
      F3_SB:   mask = 4'b1111;
      F3_SH:   mask = 4'b0101;
      F3_SW:   mask = 4'b0001;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Execute-side request, memory write port and load-hazard signals of the
// store buffer, bundled with the buffer (slave) and its environment (master).
interface store_buffer_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [2:0]  req_funct3;
  logic        st_err;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] ld_addr;
  logic        ld_hazard;

  modport slave (
    input  req_valid, req_addr, req_data, req_funct3, mem_ready, ld_addr,
    output req_ready, st_err, mem_valid, mem_addr, mem_wdata, mem_wstrb, ld_hazard
  );

  modport master (
    output req_valid, req_addr, req_data, req_funct3, mem_ready, ld_addr,
    input  req_ready, st_err, mem_valid, mem_addr, mem_wdata, mem_wstrb, ld_hazard
  );
endinterface

// File: rtl/store_buffer_align.sv
// Combinational store lane alignment: places SB/SH/SW data into its byte
// lanes, builds the write strobes and flags misaligned or unknown widths.
module store_align
  import store_buffer_pkg::*;
(
  input  logic [1:0]  i_off,
  input  logic [31:0] i_data,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wstrb,
  output logic        o_illegal
);

  logic [3:0] w_legal_mask;
  logic [4:0] w_shamt;

  assign w_legal_mask = legal_off_mask(i_funct3);
  assign w_shamt      = {i_off, 3'b000};
  assign o_illegal    = !w_legal_mask[i_off];

  always_comb begin
    o_wdata = '0;
    o_wstrb = '0;
    case (i_funct3)
      F3_SB: begin
        o_wdata = 32'(i_data[7:0]) << w_shamt;
        o_wstrb = 4'b0001 << i_off;
      end
      F3_SH: begin
        o_wdata = 32'(i_data[15:0]) << w_shamt;
        o_wstrb = 4'b0011 << i_off;
      end
      F3_SW: begin
        o_wdata = i_data;
        o_wstrb = '1;
      end
      default: begin
        o_wdata = '0;
        o_wstrb = '0;
      end
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// In-order store FIFO between execute and the data-memory write port, with
// word-granular overlap detection against the current load address.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input logic           clk,
  input logic           rst_n,
  store_buffer_if.slave bus
);

  localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);

  st_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W:0]   r_count;
  logic             r_st_err;

  occ_e             w_occ;
  logic [31:0]      w_wdata;
  logic [3:0]       w_wstrb;
  logic             w_illegal;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  st_entry_t        w_head;
  st_entry_t        w_new;
  logic [DEPTH-1:0] w_live;
  logic             w_hazard;

  store_align u_align (
    .i_off     (bus.req_addr[1:0]),
    .i_data    (bus.req_data),
    .i_funct3  (bus.req_funct3),
    .o_wdata   (w_wdata),
    .o_wstrb   (w_wstrb),
    .o_illegal (w_illegal)
  );

  always_comb begin
    w_occ = OCC_PARTIAL;
    if (r_count == '0)
      w_occ = OCC_EMPTY;
    else if (r_count == CNT_FULL)
      w_occ = OCC_FULL;
  end

  assign bus.req_ready = (w_occ != OCC_FULL);
  assign bus.mem_valid = (w_occ != OCC_EMPTY);

  // Illegal stores still complete the handshake so the pipeline never blocks on them.
  assign w_accept = bus.req_valid && bus.req_ready;
  assign w_push   = w_accept && !w_illegal;
  assign w_pop    = bus.mem_valid && bus.mem_ready;

  assign w_new = '{addr_w: bus.req_addr[31:2], wdata: w_wdata, wstrb: w_wstrb};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_st_err <= 1'b0;
    end else begin
      r_st_err <= w_accept && w_illegal;
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_new;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head = r_mem[r_rd_ptr];

  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wstrb = '0;
    if (bus.mem_valid) begin
      bus.mem_addr  = {w_head.addr_w, 2'b00};
      bus.mem_wdata = w_head.wdata;
      bus.mem_wstrb = w_head.wstrb;
    end
  end

  assign bus.st_err = r_st_err;

  // A slot is live when its distance from the read pointer (mod DEPTH) is below count.
  always_comb begin
    w_live   = '0;
    w_hazard = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_live[i] = {1'b0, PTR_W'(PTR_W'(i) - r_rd_ptr)} < r_count;
      if (w_live[i] && (r_mem[i].addr_w == bus.ld_addr[31:2])) w_hazard = 1'b1;
    end
  end

  assign bus.ld_hazard = w_hazard;

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus random
// traffic, compared against a queue-based byte-lane reference model.
module tb_store_buffer;

  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [29:0] aw;
    logic [31:0] wd;
    logic [3:0]  ws;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  store_buffer_if bus ();

  store_buffer #(.DEPTH(DEPTH)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  ent_t q[$];
  logic err_pend = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Byte-by-byte placement: store byte b of the operand into lane off+b.
  task automatic ref_align(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3,
                           output logic ok, output logic [31:0] wd, output logic [3:0] ws);
    int unsigned sz;
    int unsigned off;
    sz  = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : (f3 == 3'd2) ? 4 : 0;
    off = int'(a[1:0]);
    ok  = (sz != 0) && ((off % sz) == 0);
    wd  = '0;
    ws  = '0;
    if (ok) begin
      for (int unsigned b = 0; b < sz; b++) begin
        wd[(off + b) * 8 +: 8] = d[b * 8 +: 8];
        ws[off + b] = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    logic hz;
    ent_t h;
    h  = '0;
    hz = 1'b0;
    if (q.size() > 0) h = q[0];
    foreach (q[i]) if (q[i].aw == bus.ld_addr[31:2]) hz = 1'b1;
    check("req_ready", {31'b0, bus.req_ready}, {31'b0, q.size() < DEPTH});
    check("mem_valid", {31'b0, bus.mem_valid}, {31'b0, q.size() > 0});
    check("mem_addr", bus.mem_addr, {h.aw, 2'b00});
    check("mem_wdata", bus.mem_wdata, h.wd);
    check("mem_wstrb", {28'b0, bus.mem_wstrb}, {28'b0, h.ws});
    check("st_err", {31'b0, bus.st_err}, {31'b0, err_pend});
    check("ld_hazard", {31'b0, bus.ld_hazard}, {31'b0, hz});
  endtask

  task automatic model_update();
    logic acc, ok;
    logic [31:0] wd;
    logic [3:0] ws;
    acc = bus.req_valid && (q.size() < DEPTH);
    ref_align(bus.req_addr, bus.req_data, bus.req_funct3, ok, wd, ws);
    if ((q.size() > 0) && bus.mem_ready) void'(q.pop_front());
    if (acc && ok) q.push_back('{aw: bus.req_addr[31:2], wd: wd, ws: ws});
    err_pend = acc && !ok;
  endtask

  // Called at posedge+1: checks mid-cycle, then advances the model at the edge.
  task automatic step();
    #3;
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_req(input logic v, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] f3);
    bus.req_valid  = v;
    bus.req_addr   = a;
    bus.req_data   = d;
    bus.req_funct3 = f3;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    set_req(1'b0, '0, '0, 3'd0);
    bus.mem_ready = 1'b0;
    bus.ld_addr   = '0;

    #2;
    check_outputs();
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Byte store into lane 3
    set_req(1'b1, 32'h0000_1003, 32'hDEAD_BEEF, 3'b000);
    bus.mem_ready = 1'b1;
    step();
    set_req(1'b0, '0, '0, 3'd0);
    check("sb_valid", {31'b0, bus.mem_valid}, 32'd1);
    check("sb_addr", bus.mem_addr, 32'h0000_1000);
    check("sb_wdata", bus.mem_wdata, 32'hEF00_0000);
    check("sb_wstrb", {28'b0, bus.mem_wstrb}, 32'h8);
    step();
    step();

    // Halfword store, then misaligned halfword
    bus.mem_ready = 1'b0;
    set_req(1'b1, 32'h0000_2002, 32'h0000_ABCD, 3'b001);
    step();
    set_req(1'b1, 32'h0000_2001, 32'h0000_1234, 3'b001);
    check("sh_wdata", bus.mem_wdata, 32'hABCD_0000);
    check("sh_wstrb", {28'b0, bus.mem_wstrb}, 32'hC);
    step();
    set_req(1'b0, '0, '0, 3'd0);
    check("sh_mis_err", {31'b0, bus.st_err}, 32'd1);
    step();
    check("sh_mis_err_clr", {31'b0, bus.st_err}, 32'd0);
    check("sh_mis_not_queued", bus.mem_addr, 32'h0000_2000);
    bus.mem_ready = 1'b1;
    step();
    step();

    // Fill to DEPTH, refused push while full even with mem_ready, then drain
    bus.mem_ready = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      set_req(1'b1, 32'h10 + 4 * i, 32'hA000_0000 + i, 3'b010);
      step();
    end
    check("full_ready", {31'b0, bus.req_ready}, 32'd0);
    set_req(1'b1, 32'h20, 32'h5555_5555, 3'b010);
    bus.mem_ready = 1'b1;
    step();
    set_req(1'b0, '0, '0, 3'd0);
    check("after_full_ready", {31'b0, bus.req_ready}, 32'd1);
    check("drain_order", bus.mem_addr, 32'h14);
    for (int unsigned i = 0; i < 4; i++) step();
    check("drained", {31'b0, bus.mem_valid}, 32'd0);

    // Simultaneous push/pop at count 2 across pointer wrap
    bus.mem_ready = 1'b0;
    for (int unsigned i = 0; i < 2; i++) begin
      set_req(1'b1, 32'h100 + 4 * i, 32'h1111_0000 + i, 3'b010);
      step();
    end
    bus.mem_ready = 1'b1;
    for (int unsigned i = 0; i < 10; i++) begin
      set_req(1'b1, 32'h200 + 4 * i, $urandom, 3'b010);
      step();
      check("pp_ready", {31'b0, bus.req_ready}, 32'd1);
    end
    set_req(1'b0, '0, '0, 3'd0);
    for (int unsigned i = 0; i < 3; i++) step();

    // Word-granular load hazard and same-cycle accept exclusion
    bus.mem_ready = 1'b0;
    set_req(1'b1, 32'h0000_3001, 32'h0000_0077, 3'b000);
    step();
    set_req(1'b0, '0, '0, 3'd0);
    bus.ld_addr = 32'h0000_3002;
    #1;
    check("hazard_hit", {31'b0, bus.ld_hazard}, 32'd1);
    bus.ld_addr = 32'h0000_3004;
    #1;
    check("hazard_miss", {31'b0, bus.ld_hazard}, 32'd0);
    set_req(1'b1, 32'h0000_5000, 32'h1, 3'b010);
    bus.ld_addr = 32'h0000_5002;
    #1;
    check("hazard_new_req", {31'b0, bus.ld_hazard}, 32'd0);
    step();
    set_req(1'b0, '0, '0, 3'd0);
    step();
    bus.mem_ready = 1'b1;
    for (int unsigned i = 0; i < 3; i++) step();

    // Asynchronous reset with entries pending
    bus.mem_ready = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      set_req(1'b1, 32'h40 + 4 * i, 32'hC0DE_0000 + i, 3'b010);
      step();
    end
    set_req(1'b0, '0, '0, 3'd0);
    bus.ld_addr = 32'h40;
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    err_pend = 1'b0;
    check_outputs();
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_ready = 1'b1;
    for (int unsigned i = 0; i < 3; i++) step();

    // Random traffic
    for (int unsigned n = 0; n < 400; n++) begin
      int unsigned r;
      logic [2:0] f3;
      r  = $urandom_range(0, 9);
      f3 = (r < 3) ? 3'd0 : (r < 6) ? 3'd1 : (r < 8) ? 3'd2 : 3'($urandom_range(3, 7));
      set_req(1'($urandom_range(0, 1)),
              32'h0000_6000 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3),
              $urandom, f3);
      bus.mem_ready = ($urandom_range(0, 2) != 0);
      bus.ld_addr   = 32'h0000_6000 + ($urandom_range(0, 9) << 2) + $urandom_range(0, 3);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
